// File: rtl/store_unit_if.sv
// Store-unit bus bundle: core-side store request plus the word-wide write port
// toward data memory. The master drives requests and acks; the slave is the unit.
interface store_unit_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  funct3;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        st_done;
  logic        st_err;

  modport master (
    output st_valid, st_addr, st_data, funct3, mem_ack,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_be, st_done, st_err
  );

  modport slave (
    input  st_valid, st_addr, st_data, funct3, mem_ack,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be, st_done, st_err
  );
endinterface

// File: rtl/store_unit.sv
// RISC-V style store unit: turns SB/SH/SW requests into one or two word-aligned
// byte-enabled write beats, with done/error pulses back to the core.
module store_unit #(
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic [2:0]  funct3_reg;
  logic        done_reg;
  logic        err_reg;

  logic        accept;
  logic        req_legal;
  logic        req_reject;
  logic        final_ack;
  logic        mem_req;
  logic        in_beat2;
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [7:0]  be_span;
  logic [63:0] data_span;
  logic [31:0] beat_addr;
  logic [3:0]  be_out;
  logic [31:0] wdata_out;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] o);
    return ((f3 == 3'b001) && (o == 2'd3)) || ((f3 == 3'b010) && (o != 2'd0));
  endfunction

  // Request decode happens on the live inputs so a reject never leaves IDLE.
  always_comb begin
    req_legal  = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010);
    req_reject = !req_legal ||
                 ((ALLOW_MISALIGN == 0) && is_misaligned(bus.funct3, bus.st_addr[1:0]));
    accept     = bus.st_valid && (state_reg == IDLE);
  end

  always_comb begin
    state_next = state_reg;
    final_ack  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && !req_reject) begin
          state_next = BEAT1;
        end
      end
      BEAT1: begin
        if (bus.mem_ack) begin
          if (is_misaligned(funct3_reg, addr_reg[1:0])) begin
            state_next = BEAT2;
          end else begin
            state_next = IDLE;
            final_ack  = 1'b1;
          end
        end
      end
      BEAT2: begin
        if (bus.mem_ack) begin
          state_next = IDLE;
          final_ack  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_reg   <= 32'h0;
      data_reg   <= 32'h0;
      funct3_reg <= 3'b000;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= final_ack;
      err_reg   <= accept && req_reject;
      if (accept && !req_reject) begin
        addr_reg   <= bus.st_addr;
        data_reg   <= bus.st_data;
        funct3_reg <= bus.funct3;
      end
    end
  end

  // Shift mask and data across a 2-word span; the low word is beat 1, the high word beat 2.
  always_comb begin
    off = addr_reg[1:0];
    case (funct3_reg)
      3'b000:  mask = 4'b0001;
      3'b001:  mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    be_span   = {4'b0000, mask} << off;
    data_span = {32'h0, data_reg} << {off, 3'b000};
    mem_req   = (state_reg == BEAT1) || (state_reg == BEAT2);
    in_beat2  = (state_reg == BEAT2);
    beat_addr = in_beat2 ? ({addr_reg[31:2], 2'b00} + 32'd4) : {addr_reg[31:2], 2'b00};
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign be_out[gi] = mem_req && (in_beat2 ? be_span[gi+4] : be_span[gi]);
      assign wdata_out[8*gi +: 8] = !mem_req ? 8'h00 :
                                    (in_beat2 ? data_span[32+8*gi +: 8] : data_span[8*gi +: 8]);
    end
  endgenerate

  assign bus.mem_req   = mem_req;
  assign bus.mem_be    = be_out;
  assign bus.mem_wdata = wdata_out;
  assign bus.mem_addr  = mem_req ? beat_addr : 32'h0;
  assign bus.st_ready  = (state_reg == IDLE);
  assign bus.st_done   = done_reg;
  assign bus.st_err    = err_reg;

endmodule
